// File: rtl/trap_pkg.sv
// trap_pkg: shared constants for the machine-mode trap sequencer.
//   - CSR addresses touched during trap entry / mret
//   - mcause codes for synchronous exceptions
//   - CSR write/set/clear (wsc) encodings
//   - FSM state encoding
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] CAUSE_LFAULT  = 32'd5;
  localparam logic [31:0] CAUSE_SFAULT  = 32'd7;

  localparam logic [1:0] WSC_NONE  = 2'b00;
  localparam logic [1:0] WSC_WRITE = 2'b01;
  localparam logic [1:0] WSC_SET   = 2'b10;
  localparam logic [1:0] WSC_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    S_STATUS = 3'd1,
    S_EPC    = 3'd2,
    S_CAUSE  = 3'd3,
    S_JUMP   = 3'd4,
    R_STATUS = 3'd5,
    R_JUMP   = 3'd6
  } state_t;

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: fixed-priority trap cause selector.
// Ports:
//   i_illegal_inst, i_ecall_m, i_l_access_fault, i_s_access_fault : sync exceptions
//   i_interrupt, i_mie : interrupt request and global enable (mstatus.MIE)
//   o_valid : some trap is being taken
//   o_cause : mcause value of the winning request
// Priority: illegal > ecall > load fault > store fault > interrupt.
module trap_prio_enc
  import trap_pkg::*;
#(
  parameter logic [31:0] INT_CAUSE = 32'h8000000B
) (
  input  logic        i_illegal_inst,
  input  logic        i_ecall_m,
  input  logic        i_l_access_fault,
  input  logic        i_s_access_fault,
  input  logic        i_interrupt,
  input  logic        i_mie,
  output logic        o_valid,
  output logic [31:0] o_cause
);

  always_comb begin
    o_valid = 1'b1;
    o_cause = 32'd0;
    if (i_illegal_inst)        o_cause = CAUSE_ILLEGAL;
    else if (i_ecall_m)        o_cause = CAUSE_ECALL_M;
    else if (i_l_access_fault) o_cause = CAUSE_LFAULT;
    else if (i_s_access_fault) o_cause = CAUSE_SFAULT;
    else if (i_interrupt && i_mie) o_cause = INT_CAUSE;
    else                       o_valid = 1'b0;
  end

endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: multi-cycle machine-mode trap entry and mret sequencer
// sitting at the MEM stage. Trap entry writes mstatus, mepc, mcause and
// redirects to mtvec; mret restores MIE from MPIE and redirects to mepc.
// While idle, CSR instructions from MEM pass straight through to the CSR file.
// Ports:
//   clk, rst (async, active-low)
//   interrupt, illegal_inst, ecall_m, l_access_fault, s_access_fault, mret
//   epc_cur      : PC of the trapping instruction
//   csr_req/csr_wen/csr_addr/csr_wdata_in/csr_mode_in : CSR instruction in MEM
//   csr_rdata, mstatus : combinational read data / live mstatus from CSR file
//   csr_w/csr_raddr/csr_waddr/csr_wdata/csr_wsc : CSR file port
//   csr_r_data_out : CSR read value to the MEM result mux
//   pc_redirect/redirect_valid : redirect target and one-cycle strobe
//   flush, stall : pipeline control
//   dbg_state    : current FSM state for observation
// Handshake: redirect_valid is a single-cycle strobe with no ready; the
// fetch stage must accept pc_redirect in the cycle it is asserted.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter logic [31:0] INT_CAUSE = 32'h8000000B,
  parameter logic [1:0]  MPP_VAL   = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt,
  input  logic        illegal_inst,
  input  logic        ecall_m,
  input  logic        l_access_fault,
  input  logic        s_access_fault,
  input  logic        mret,
  input  logic [31:0] epc_cur,
  input  logic        csr_req,
  input  logic        csr_wen,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata_in,
  input  logic [1:0]  csr_mode_in,
  input  logic [31:0] csr_rdata,
  input  logic [31:0] mstatus,
  output logic        csr_w,
  output logic [11:0] csr_raddr,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic [1:0]  csr_wsc,
  output logic [31:0] csr_r_data_out,
  output logic [31:0] pc_redirect,
  output logic        redirect_valid,
  output logic        flush,
  output logic        stall,
  output logic [2:0]  dbg_state
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic        w_trap;
  logic [31:0] w_cause;

  trap_prio_enc #(.INT_CAUSE(INT_CAUSE)) u_prio (
    .i_illegal_inst   (illegal_inst),
    .i_ecall_m        (ecall_m),
    .i_l_access_fault (l_access_fault),
    .i_s_access_fault (s_access_fault),
    .i_interrupt      (interrupt),
    .i_mie            (mstatus[3]),
    .o_valid          (w_trap),
    .o_cause          (w_cause)
  );

  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cause <= 32'd0;
      r_epc   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_trap) begin
        r_cause <= w_cause;
        r_epc   <= epc_cur;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    csr_w          = 1'b0;
    csr_raddr      = 12'd0;
    csr_waddr      = 12'd0;
    csr_wdata      = 32'd0;
    csr_wsc        = WSC_NONE;
    csr_r_data_out = 32'd0;
    pc_redirect    = 32'd0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    stall          = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (w_trap) begin
          // Trap beats mret and suppresses any CSR write this cycle.
          w_state_nxt = S_STATUS;
          flush       = 1'b1;
        end else if (mret) begin
          w_state_nxt = R_STATUS;
          flush       = 1'b1;
        end else if (csr_req) begin
          csr_raddr      = csr_addr;
          csr_waddr      = csr_addr;
          csr_wdata      = csr_wdata_in;
          csr_wsc        = csr_mode_in;
          csr_w          = csr_wen;
          csr_r_data_out = csr_rdata;
        end
      end
      S_STATUS: begin
        // MPP <= MPP_VAL, MPIE <= MIE, MIE <= 0.
        csr_w       = 1'b1;
        csr_waddr   = CSR_MSTATUS;
        csr_wsc     = WSC_WRITE;
        csr_wdata   = {mstatus[31:13], MPP_VAL, mstatus[10:8], mstatus[3],
                       mstatus[6:4], 1'b0, mstatus[2:0]};
        w_state_nxt = S_EPC;
      end
      S_EPC: begin
        csr_w       = 1'b1;
        csr_waddr   = CSR_MEPC;
        csr_wsc     = WSC_WRITE;
        csr_wdata   = r_epc;
        w_state_nxt = S_CAUSE;
      end
      S_CAUSE: begin
        csr_w       = 1'b1;
        csr_waddr   = CSR_MCAUSE;
        csr_wsc     = WSC_WRITE;
        csr_wdata   = r_cause;
        csr_raddr   = CSR_MTVEC;
        w_state_nxt = S_JUMP;
      end
      S_JUMP: begin
        // Direct mode only: mtvec low bits are the mode field.
        csr_raddr      = CSR_MTVEC;
        redirect_valid = 1'b1;
        pc_redirect    = {csr_rdata[31:2], 2'b00};
        w_state_nxt    = IDLE;
      end
      R_STATUS: begin
        // MIE <= MPIE, MPIE <= 1.
        csr_w       = 1'b1;
        csr_waddr   = CSR_MSTATUS;
        csr_wsc     = WSC_WRITE;
        csr_wdata   = {mstatus[31:8], 1'b1, mstatus[6:4], mstatus[7],
                       mstatus[2:0]};
        w_state_nxt = R_JUMP;
      end
      R_JUMP: begin
        csr_raddr      = CSR_MEPC;
        redirect_valid = 1'b1;
        pc_redirect    = csr_rdata;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Hold every output quiet while reset is asserted, independent of inputs.
    if (!rst) begin
      csr_w          = 1'b0;
      csr_raddr      = 12'd0;
      csr_waddr      = 12'd0;
      csr_wdata      = 32'd0;
      csr_wsc        = WSC_NONE;
      csr_r_data_out = 32'd0;
      pc_redirect    = 32'd0;
      redirect_valid = 1'b0;
      flush          = 1'b0;
      stall          = 1'b0;
    end
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter INT_CAUSE, default 32'h8000000B, the mcause value written for an interrupt (machine external).
REQ-002 SHALL have parameter MPP_VAL, default 2'b11, the value written to mstatus.MPP[12:11] on trap entry.
REQ-003 SHALL have the following ports; clock and reset first. There is one clock. Reset is asynchronous and active-low.
- clk, in, 1: the single clock.
- rst, in, 1: reset, asynchronous, active-low.
- interrupt, illegal_inst, ecall_m, l_access_fault, s_access_fault, mret, in, 1 each: trap and return requests from MEM.
- epc_cur, in, 32: PC of the faulting or interrupted instruction.
- csr_req, in, 1: a CSR instruction is present in MEM.
- csr_wen, in, 1: that instruction writes (0 for CSRRS/CSRRC with x0 or zimm=0).
- csr_addr, in, 12: address of the CSR being accessed.
- csr_wdata_in, in, 32: source operand, already muxed between register and zimm.
- csr_mode_in, in, 2: 01 write, 10 set, 11 clear.
- csr_rdata, in, 32: combinational read data from the CSR file.
- mstatus, in, 32: live mstatus from the CSR file.
- csr_w, out, 1: CSR file port, write enable.
- csr_raddr, out, 12: CSR file port, read address.
- csr_waddr, out, 12: CSR file port, write address.
- csr_wdata, out, 32: CSR file port, write data.
- csr_wsc, out, 2: CSR file port, write/set/clear mode.
- csr_r_data_out, out, 32: read data returned to the MEM result mux.
- pc_redirect, out, 32: redirect target.
- redirect_valid, out, 1: one-cycle redirect strobe.
- flush, out, 1: flush FD/DE/EM/MW and cancel WB RegWrite.
- stall, out, 1: freeze PC and all pipeline registers.

Function
REQ-004 SHALL detect a trap in IDLE when any synchronous exception is asserted, or when interrupt=1 with mstatus[3] (MIE)=1.
REQ-005 SHALL give trap causes priority illegal_inst (2) > ecall_m (11) > l_access_fault (5) > s_access_fault (7) > interrupt (INT_CAUSE).
REQ-006 SHALL latch the cause and epc_cur at the edge that ends the detect cycle.
REQ-007 SHALL assert flush combinationally in the detect cycle and in the mret accept cycle.
REQ-008 SHALL assert stall whenever state != IDLE.
REQ-009 SHALL implement the FSM states IDLE, S_STATUS, S_EPC, S_CAUSE, S_JUMP, R_STATUS, R_JUMP.
REQ-010 SHALL transition IDLE to S_STATUS on a trap, IDLE to R_STATUS on mret, and otherwise stay in IDLE.
REQ-011 SHALL transition S_STATUS to S_EPC to S_CAUSE to S_JUMP to IDLE, and R_STATUS to R_JUMP to IDLE, each unconditionally after one cycle.
REQ-012 In S_STATUS SHALL write 0x300 with wsc=01 and data = mstatus with bit7 (MPIE) taking the old MIE, bit3 (MIE) cleared, and bits[12:11] = MPP_VAL.
REQ-013 In S_EPC SHALL write 0x341 with wsc=01 and data = the latched epc.
REQ-014 In S_CAUSE SHALL write 0x342 with wsc=01 and data = the latched cause, and drive csr_raddr=0x305 (mtvec).
REQ-015 In S_JUMP SHALL drive csr_raddr=0x305, redirect_valid=1, pc_redirect = {csr_rdata[31:2],2'b00}, and csr_w=0.
REQ-016 In R_STATUS SHALL write 0x300 with bit3 (MIE) taking the old MPIE and bit7 (MPIE) set to 1.
REQ-017 In R_JUMP SHALL drive csr_raddr=0x341, redirect_valid=1, pc_redirect=csr_rdata, and csr_w=0.
REQ-018 In IDLE with no trap and no mret SHALL pass a CSR instruction through in the same cycle: csr_raddr=csr_waddr=csr_addr, csr_wdata=csr_wdata_in, csr_wsc=csr_mode_in, csr_w=csr_req&csr_wen, and csr_r_data_out=csr_rdata (old value).
REQ-019 Outside that pass-through case, SHALL drive csr_w=0 (except in the write states) and csr_r_data_out=0.
REQ-020 Latency SHALL be: trap detected in cycle 0 gives redirect_valid in cycle 4; mret accepted in cycle 0 gives redirect_valid in cycle 2.
REQ-021 Simultaneous events: a trap SHALL beat mret, and a trap or mret SHALL suppress any CSR instruction write in the same cycle.
REQ-022 Trap, mret and csr_req inputs SHALL be ignored while state != IDLE, including an interrupt arriving mid-sequence.
REQ-023 An interrupt with MIE=0 SHALL be ignored with no flush.
REQ-024 csr_wdata, csr_waddr, csr_raddr and csr_wsc SHALL be 0 when not otherwise specified.

Reset
REQ-025 rst=0 SHALL asynchronously force state=IDLE and latched cause/epc=0; while in reset, redirect_valid, flush, stall and csr_w SHALL be 0.
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence with no further CSR write.
REQ-027 Reset deassertion SHALL be sampled synchronously by clk.

Structure
REQ-028 Package trap_pkg SHALL hold the CSR addresses (0x300, 0x305, 0x341, 0x342), cause codes, wsc encodings and the FSM state encoding.
REQ-029 Cause selection SHALL live in sub-module trap_prio_enc (6 request inputs, outputs valid and cause[31:0]).
REQ-030 The CSR port outputs SHALL be a combinational mux on state; only the state and the latches SHALL be registered.

Verification
REQ-031 illegal_inst=1, epc_cur=0x100, mstatus=0x8, mtvec=0x200 -> flush in cycle 0; writes mstatus=0x1880, mepc=0x100, mcause=2; redirect_valid with pc_redirect=0x200 in cycle 4.
REQ-032 interrupt=1 with MIE=1 and ecall_m=1 together -> mcause=11; interrupt=1 with MIE=0 -> no flush and state stays IDLE.
REQ-033 mret with mstatus=0x80 and mepc=0x104 -> mstatus written 0x88; redirect to 0x104 in cycle 2.
REQ-034 csr_req with CSRRS (mode 10) to 0x305, wdata=0x3, csr_wen=1, in IDLE -> same-cycle write and old value on csr_r_data_out; the same request plus l_access_fault -> no CSR write, mcause=5.
REQ-035 Trap sequence in S_EPC, then rst=0 -> all outputs 0 immediately; after release, state is IDLE and no mcause write occurs.
REQ-036 interrupt pulses during S_CAUSE -> ignored; exactly one redirect is produced.
